// File: rtl/zigzag_dequant_assembler.sv
`default_nettype none
// ============================================================================
// Module      : zigzag_dequant_assembler
// Description : Accepts zigzag-ordered entropy-decoded coefficients, multiplies
//               each by a loadable quant table entry, saturates to OUT_W bits
//               and scatters it to its row-major lane. A completed 8x8 block
//               is presented on data_out with a single-cycle m_valid pulse.
//               Optional feature macro: DC_PRED_EN (DC difference decoding
//               with a running predictor, cleared by dc_clear).
// Revision    : 1.0 - initial release
// ============================================================================
module zigzag_dequant_assembler #(
  parameter int COEF_W = 11,
  parameter int Q_W    = 8,
  parameter int OUT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  coef_valid,
  output logic                  coef_ready,
  input  logic [COEF_W-1:0]     coef_data,
  input  logic                  coef_last,
  input  logic                  qt_we,
  input  logic [5:0]            qt_addr,
  input  logic [Q_W-1:0]        qt_data,
  input  logic                  dc_clear,
  output logic [64*OUT_W-1:0]   data_out,
  output logic                  m_valid
);

  localparam int PROD_W = COEF_W + Q_W + 1;

  localparam logic [0:0] c_FILL = 1'b0;
  localparam logic [0:0] c_EMIT = 1'b1;

  localparam logic signed [PROD_W-1:0] c_SAT_MAX = PROD_W'((1 << (OUT_W-1)) - 1);
  localparam logic signed [PROD_W-1:0] c_SAT_MIN = -c_SAT_MAX - PROD_W'(1);

  // JPEG zigzag index -> natural (row-major) index
  localparam logic [5:0] c_ZZ2NAT [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  logic [0:0]                r_state;
  logic [0:0]                w_next_state;
  logic [5:0]                r_zz;
  logic [Q_W-1:0]            r_qt [64];
  logic [64*OUT_W-1:0]       r_buf;
  logic [64*OUT_W-1:0]       r_data_out;
  logic [64*OUT_W-1:0]       w_buf_next;
  logic                      w_accept;
  logic                      w_final;
  logic [COEF_W-1:0]         w_coef;
  logic signed [PROD_W-1:0]  w_prod;
  logic [OUT_W-1:0]          w_sat;
  logic [5:0]                w_nat;

  assign w_accept = coef_valid && coef_ready;
  assign w_final  = w_accept && ((r_zz == 6'd63) || coef_last);
  assign w_nat    = c_ZZ2NAT[r_zz];
  assign data_out = r_data_out;

`ifdef DC_PRED_EN
  logic [COEF_W-1:0] r_pred;
  logic [COEF_W-1:0] w_dc_base;
  logic [COEF_W:0]   w_dc_sum;
  logic [COEF_W-1:0] w_dc;

  // DC reconstruction: predictor (or zero when clearing) plus difference, clamped to COEF_W
  always_comb begin
    w_dc_base = dc_clear ? '0 : r_pred;
    w_dc_sum  = {w_dc_base[COEF_W-1], w_dc_base} + {coef_data[COEF_W-1], coef_data};
    if (w_dc_sum[COEF_W] != w_dc_sum[COEF_W-1])
      w_dc = w_dc_sum[COEF_W] ? {1'b1, {(COEF_W-1){1'b0}}} : {1'b0, {(COEF_W-1){1'b1}}};
    else
      w_dc = w_dc_sum[COEF_W-1:0];
    w_coef = (r_zz == 6'd0) ? w_dc : coef_data;
  end

  // Predictor follows each decoded DC; restart markers zero it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_pred <= '0;
    else if (w_accept && (r_zz == 6'd0))
      r_pred <= w_dc;
    else if (dc_clear)
      r_pred <= '0;
  end
`else
  logic w_unused;
  assign w_unused = dc_clear;
  assign w_coef   = coef_data;
`endif

  // Dequantise (quant entry is unsigned) and saturate into one signed lane
  always_comb begin
    w_prod = $signed({{(Q_W+1){w_coef[COEF_W-1]}}, w_coef}) *
             $signed({{(COEF_W+1){1'b0}}, r_qt[r_zz]});
    if (w_prod > c_SAT_MAX)
      w_sat = c_SAT_MAX[OUT_W-1:0];
    else if (w_prod < c_SAT_MIN)
      w_sat = c_SAT_MIN[OUT_W-1:0];
    else
      w_sat = w_prod[OUT_W-1:0];
  end

  // Assembly buffer with the current coefficient scattered into its lane
  always_comb begin
    w_buf_next = r_buf;
    w_buf_next[int'(w_nat)*OUT_W +: OUT_W] = w_sat;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= c_FILL;
    else
      r_state <= w_next_state;
  end

  // Next-state: leave FILL on the block's final accept, EMIT lasts one cycle
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_FILL:  if (w_final) w_next_state = c_EMIT;
      c_EMIT:  w_next_state = c_FILL;
      default: w_next_state = c_FILL;
    endcase
  end

  // Outputs: ready while filling, pulse while emitting
  always_comb begin
    coef_ready = (r_state == c_FILL);
    m_valid    = (r_state == c_EMIT);
  end

  // Datapath: quant table, index counter, buffer and output capture.
  // The finished block is captured on the final accept edge so data_out is
  // valid throughout EMIT; the buffer is cleared on that same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zz       <= '0;
      r_buf      <= '0;
      r_data_out <= '0;
      for (int i = 0; i < 64; i++) r_qt[i] <= Q_W'(1);
    end else begin
      if (qt_we) r_qt[qt_addr] <= qt_data;
      if (w_final) begin
        r_data_out <= w_buf_next;
        r_buf      <= '0;
        r_zz       <= '0;
      end else if (w_accept) begin
        r_buf <= w_buf_next;
        r_zz  <= r_zz + 6'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_zigzag_dequant_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_zigzag_dequant_assembler
// Description : Directed, table-driven bench for zigzag_dequant_assembler.
//               Runs the DC_PRED_EN section only when that macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zigzag_dequant_assembler;

  localparam int COEF_W = 11;
  localparam int Q_W    = 8;
  localparam int OUT_W  = 8;

  localparam int ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 coef_valid = 1'b0;
  logic                 coef_ready;
  logic [COEF_W-1:0]    coef_data = '0;
  logic                 coef_last = 1'b0;
  logic                 qt_we = 1'b0;
  logic [5:0]           qt_addr = '0;
  logic [Q_W-1:0]       qt_data = '0;
  logic                 dc_clear = 1'b0;
  logic [64*OUT_W-1:0]  data_out;
  logic                 m_valid;

  int total = 0;
  int bad   = 0;

  zigzag_dequant_assembler #(.COEF_W(COEF_W), .Q_W(Q_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .coef_valid(coef_valid), .coef_ready(coef_ready),
    .coef_data(coef_data), .coef_last(coef_last), .qt_we(qt_we),
    .qt_addr(qt_addr), .qt_data(qt_data), .dc_clear(dc_clear),
    .data_out(data_out), .m_valid(m_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    int         a;     // zigzag position carrying the coefficient (with last)
    int         q;     // quant entry written at that position
    int         c;     // coefficient value
    int         lane;  // expected natural lane
    logic [7:0] v;     // expected lane value
  } vec_t;

  vec_t vt [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic write_qt(input int a, input int q);
    qt_we = 1'b1; qt_addr = 6'(a); qt_data = Q_W'(q);
    tick();
    qt_we = 1'b0;
  endtask

  // Zero coefficients up to position a, then value c with coef_last at a
  task automatic feed_single(input int a, input int c);
    for (int i = 0; i <= a; i++) begin
      coef_valid = 1'b1;
      coef_data  = (i == a) ? COEF_W'(c) : '0;
      coef_last  = (i == a);
      tick();
    end
    coef_valid = 1'b0;
    coef_last  = 1'b0;
  endtask

  initial begin
    logic [511:0] exp;
    int seen;

    vt[0] = '{a: 0,  q: 16,  c: 5,     lane: 0,  v: 8'h50};
    vt[1] = '{a: 1,  q: 255, c: 1000,  lane: 1,  v: 8'h7F};
    vt[2] = '{a: 1,  q: 255, c: -1000, lane: 1,  v: 8'h80};
    vt[3] = '{a: 2,  q: 3,   c: -7,    lane: 8,  v: 8'hEB};
    vt[4] = '{a: 4,  q: 10,  c: 12,    lane: 9,  v: 8'h78};
    vt[5] = '{a: 3,  q: 2,   c: 64,    lane: 16, v: 8'h7F};
    vt[6] = '{a: 5,  q: 2,   c: -64,   lane: 2,  v: 8'h80};
    vt[7] = '{a: 9,  q: 200, c: -1024, lane: 24, v: 8'h80};
    vt[8] = '{a: 63, q: 1,   c: -128,  lane: 63, v: 8'h80};
    vt[9] = '{a: 62, q: 0,   c: 500,   lane: 62, v: 8'h00};

    // ---- reset state
    tick(); tick();
    chk("rst_m_valid", 512'(m_valid), 512'(0));
    chk("rst_data_out", data_out, '0);
    rst = 1'b0;
    tick();
    chk("rst_ready", 512'(coef_ready), 512'(1));

    // ---- full ramp block with unit quant table
    seen = 0;
    exp  = '0;
    for (int i = 0; i < 64; i++) begin
      coef_valid = 1'b1;
      coef_data  = COEF_W'(i);
      coef_last  = 1'b0;
      exp[ZZ[i]*8 +: 8] = 8'(i);
      tick();
      if (i < 63 && m_valid) seen++;
    end
    coef_valid = 1'b0;
    chk("ramp_no_early_valid", 512'(seen), 512'(0));
    chk("ramp_m_valid", 512'(m_valid), 512'(1));
    chk("ramp_ready_low", 512'(coef_ready), 512'(0));
    chk("ramp_data", data_out, exp);
    chk("ramp_lane8", 512'(data_out[8*8 +: 8]), 512'(2));
    tick();
    chk("ramp_pulse_one_cycle", 512'(m_valid), 512'(0));
    chk("ramp_hold", data_out, exp);

    // ---- back-to-back blocks, valid held high (dc_clear held: must be harmless)
    dc_clear   = 1'b1;
    coef_valid = 1'b1; coef_data = 11'd7; coef_last = 1'b0;
    tick(); tick();
    coef_last = 1'b1;
    tick();
    exp = '0; exp[0 +: 8] = 8'd7; exp[1*8 +: 8] = 8'd7; exp[8*8 +: 8] = 8'd7;
    chk("b2b_a_valid", 512'(m_valid), 512'(1));
    chk("b2b_a_data", data_out, exp);
    coef_data = 11'd9;
    tick();
    chk("b2b_gap_valid", 512'(m_valid), 512'(0));
    chk("b2b_gap_ready", 512'(coef_ready), 512'(1));
    tick();
    coef_valid = 1'b0; coef_last = 1'b0;
    exp = '0; exp[0 +: 8] = 8'd9;
    chk("b2b_b_valid", 512'(m_valid), 512'(1));
    chk("b2b_b_data", data_out, exp);
    tick();

    // ---- table-driven single-coefficient blocks
    for (int k = 0; k < 10; k++) begin
      write_qt(vt[k].a, vt[k].q);
      feed_single(vt[k].a, vt[k].c);
      exp = '0;
      exp[vt[k].lane*8 +: 8] = vt[k].v;
      chk($sformatf("vec%0d_valid", k), 512'(m_valid), 512'(1));
      chk($sformatf("vec%0d_ready", k), 512'(coef_ready), 512'(0));
      chk($sformatf("vec%0d_data", k), data_out, exp);
      tick();
      chk($sformatf("vec%0d_after", k), 512'(m_valid), 512'(0));
    end
    dc_clear = 1'b0;

    // ---- reset after 30 accepts: block discarded, table reverts to 1
    for (int i = 0; i < 30; i++) begin
      coef_valid = 1'b1; coef_data = 11'd3; coef_last = 1'b0;
      tick();
    end
    coef_valid = 1'b0;
    rst = 1'b1;
    #2;
    chk("midrst_no_valid", 512'(m_valid), 512'(0));
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_no_valid2", 512'(m_valid), 512'(0));
    chk("midrst_data_cleared", data_out, '0);
    coef_valid = 1'b1; coef_data = 11'd5; coef_last = 1'b0;
    tick();
    coef_data = 11'd6; coef_last = 1'b1;
    tick();
    coef_valid = 1'b0; coef_last = 1'b0;
    exp = '0; exp[0 +: 8] = 8'd5; exp[1*8 +: 8] = 8'd6;
    chk("midrst_valid", 512'(m_valid), 512'(1));
    chk("midrst_data", data_out, exp);
    tick();

`ifdef DC_PRED_EN
    // ---- DC prediction
    dc_clear = 1'b1; tick(); dc_clear = 1'b0;
    feed_single(0, 10);
    chk("dc_first", 512'(data_out[7:0]), 512'(8'd10));
    tick();
    feed_single(0, -3);
    chk("dc_second", 512'(data_out[7:0]), 512'(8'd7));
    tick();
    dc_clear = 1'b1; tick(); dc_clear = 1'b0;
    feed_single(0, 4);
    chk("dc_cleared", 512'(data_out[7:0]), 512'(8'd4));
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
